// File: rtl/gactx_ctrl_master_if.sv
// AXI4-Lite bus between the GACTX control master and the kernel s_axi_control slave.
// Every channel is valid/ready: a beat transfers on a rising edge where both are high,
// and the source holds valid and its payload stable from assertion until that edge.
interface gactx_ctrl_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/gactx_ctrl_master.sv
// Command-driven AXI4-Lite master for the GACTX kernel control slave: one
// write, read or bounded poll per command, one response back per command.
module gactx_ctrl_master #(
  parameter int C_ADDR_WIDTH   = 12,
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_POLL_GAP     = 16,
  parameter int C_POLL_TIMEOUT = 65535
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [C_DATA_WIDTH-1:0]   cmd_mask,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,

  output logic                      busy,
  output logic [2:0]                dbg_state,

  gactx_ctrl_master_if.master       m_axi
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RD_A = 3'd3,
    S_RD_R = 3'd4,
    S_GAP  = 3'd5,
    S_RSP  = 3'd6
  } state_t;

  localparam logic [1:0]  OP_WRITE   = 2'b00;
  localparam logic [1:0]  OP_READ    = 2'b01;
  localparam logic [1:0]  OP_POLL    = 2'b10;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_BADOP = 2'b11;
  localparam logic [15:0] POLL_LIMIT = 16'(C_POLL_TIMEOUT);
  // The GAP state is left on the cycle the counter is zero, so load gap-1.
  localparam logic [15:0] GAP_LOAD   = 16'((C_POLL_GAP > 0) ? (C_POLL_GAP - 1) : 0);

  state_t                    state_q;
  logic                      cmd_ready_q;
  logic [1:0]                op_q;
  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [C_DATA_WIDTH-1:0]   wdata_q;
  logic [C_DATA_WIDTH/8-1:0] wstrb_q;
  logic [C_DATA_WIDTH-1:0]   mask_q;
  logic [15:0]               poll_cnt_q;
  logic [15:0]               gap_cnt_q;

  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;

  logic                      rsp_valid_q;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]                rsp_resp_q;
  logic                      rsp_timeout_q;

  // A write channel counts as done once its valid is gone or handshakes this cycle.
  logic aw_done_d;
  logic w_done_d;
  logic poll_match_d;
  logic poll_last_d;

  assign aw_done_d    = !awvalid_q || m_axi.awready;
  assign w_done_d     = !wvalid_q  || m_axi.wready;
  assign poll_match_d = ((m_axi.rdata & mask_q) == (wdata_q & mask_q));
  assign poll_last_d  = (poll_cnt_q == POLL_LIMIT);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      op_q          <= OP_WRITE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      mask_q        <= '0;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            mask_q      <= cmd_mask;
            poll_cnt_q  <= 16'd1;
            case (cmd_op)
              OP_WRITE: begin
                state_q   <= S_WR;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
              end
              OP_READ, OP_POLL: begin
                state_q   <= S_RD_A;
                arvalid_q <= 1'b1;
              end
              default: begin
                state_q       <= S_RSP;
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= '0;
                rsp_resp_q    <= RESP_BADOP;
                rsp_timeout_q <= 1'b0;
              end
            endcase
          end
        end

        S_WR: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            state_q  <= S_WB;
            bready_q <= 1'b1;
          end
        end

        S_WB: begin
          if (m_axi.bvalid) begin
            state_q       <= S_RSP;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= m_axi.bresp;
            rsp_timeout_q <= 1'b0;
          end
        end

        S_RD_A: begin
          if (m_axi.arready) begin
            state_q   <= S_RD_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end

        S_RD_R: begin
          if (m_axi.rvalid) begin
            rready_q      <= 1'b0;
            rsp_rdata_q   <= m_axi.rdata;
            rsp_resp_q    <= m_axi.rresp;
            rsp_timeout_q <= 1'b0;
            // Poll exit priority: bus error, then match, then attempt budget.
            if (op_q != OP_POLL || m_axi.rresp != RESP_OKAY || poll_match_d) begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
            end else if (poll_last_d) begin
              state_q       <= S_RSP;
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b1;
            end else begin
              poll_cnt_q <= poll_cnt_q + 16'd1;
              if (C_POLL_GAP == 0) begin
                state_q   <= S_RD_A;
                arvalid_q <= 1'b1;
              end else begin
                state_q   <= S_GAP;
                gap_cnt_q <= GAP_LOAD;
              end
            end
          end
        end

        S_GAP: begin
          if (gap_cnt_q == 16'd0) begin
            state_q   <= S_RD_A;
            arvalid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_gactx_ctrl_master.sv
// Directed bench for gactx_ctrl_master: behavioural AXI4-Lite slave with
// programmable ready latency and responses, command driver and response scoreboard.
module tb_gactx_ctrl_master;

  localparam int AW   = 12;
  localparam int GAP  = 4;
  localparam int TMO  = 3;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op    = '0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic [31:0]   cmd_mask  = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          busy;
  logic [2:0]    dbg_state;

  gactx_ctrl_master_if #(.ADDR_W(AW), .DATA_W(32)) m_axi_if ();

  gactx_ctrl_master #(
    .C_ADDR_WIDTH  (AW),
    .C_DATA_WIDTH  (32),
    .C_POLL_GAP    (GAP),
    .C_POLL_TIMEOUT(TMO)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .cmd_mask   (cmd_mask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .m_axi      (m_axi_if)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rd_q[$];

  int          aw_hs = 0, w_hs = 0, ar_hs = 0, valid_seen = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  int          ar_cyc_q[$];
  int          r_cyc_q[$];
  bit          busy_log [1024];

  bit aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
  bit aw_done = 0, w_done = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0;

  // Slave acts on the falling edge; a beat fires on the following rising edge.
  initial begin
    m_axi_if.awready = 1'b0;
    m_axi_if.wready  = 1'b0;
    m_axi_if.bvalid  = 1'b0;
    m_axi_if.bresp   = 2'b00;
    m_axi_if.arready = 1'b0;
    m_axi_if.rvalid  = 1'b0;
    m_axi_if.rdata   = '0;
    m_axi_if.rresp   = 2'b00;
    forever begin
      @(negedge ap_clk);
      busy_log[cyc % 1024] = busy;
      if (m_axi_if.awvalid || m_axi_if.wvalid || m_axi_if.arvalid) valid_seen++;
      if (!ap_rst_n) begin
        m_axi_if.awready = 1'b0;
        m_axi_if.wready  = 1'b0;
        m_axi_if.bvalid  = 1'b0;
        m_axi_if.arready = 1'b0;
        m_axi_if.rvalid  = 1'b0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_done = 0; w_done = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        continue;
      end
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      if (b_fire)  m_axi_if.bvalid = 1'b0;
      if (r_fire)  m_axi_if.rvalid = 1'b0;
      if (aw_done && w_done) begin
        m_axi_if.bvalid = 1'b1;
        m_axi_if.bresp  = bresp_cfg;
        aw_done = 0;
        w_done  = 0;
      end
      if (ar_fire) begin
        m_axi_if.rvalid = 1'b1;
        m_axi_if.rresp  = rresp_cfg;
        if (rd_q.size() > 0) m_axi_if.rdata = rd_q.pop_front();
        else                 m_axi_if.rdata = '0;
      end
      if (m_axi_if.awvalid) begin m_axi_if.awready = (aw_wait >= aw_lat); aw_wait++; end
      else begin m_axi_if.awready = 1'b0; aw_wait = 0; end
      if (m_axi_if.wvalid) begin m_axi_if.wready = (w_wait >= w_lat); w_wait++; end
      else begin m_axi_if.wready = 1'b0; w_wait = 0; end
      if (m_axi_if.arvalid) begin m_axi_if.arready = (ar_wait >= ar_lat); ar_wait++; end
      else begin m_axi_if.arready = 1'b0; ar_wait = 0; end

      aw_fire = m_axi_if.awvalid && m_axi_if.awready;
      w_fire  = m_axi_if.wvalid  && m_axi_if.wready;
      ar_fire = m_axi_if.arvalid && m_axi_if.arready;
      b_fire  = m_axi_if.bvalid  && m_axi_if.bready;
      r_fire  = m_axi_if.rvalid  && m_axi_if.rready;
      if (aw_fire) begin aw_hs++; last_awaddr = m_axi_if.awaddr; end
      if (w_fire)  begin w_hs++; last_wdata = m_axi_if.wdata; last_wstrb = m_axi_if.wstrb; end
      if (ar_fire) begin ar_hs++; last_araddr = m_axi_if.araddr; ar_cyc_q.push_back(cyc); end
      if (r_fire)  r_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] mask, output int acc);
    int n;
    @(negedge ap_clk);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    acc = cyc;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic [1:0] resp_e,
                         input logic to_e, output int rcyc);
    int n;
    logic [31:0] e;
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_rdata"}, rsp_rdata, e);
    check({tag, "_resp"}, 32'(rsp_resp), 32'(resp_e));
    check({tag, "_timeout"}, 32'(rsp_timeout), 32'(to_e));
    rcyc = cyc;
    @(negedge ap_clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int lat_aw [3] = '{3, 0, 0};
  int lat_w  [3] = '{0, 3, 0};

  initial begin
    int acc, rc, n, hi_cnt;
    bit stable;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        s_to;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_valids", 32'({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid}), 32'd0);
    check("rst_readies", 32'({m_axi_if.bready, m_axi_if.rready}), 32'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write with W first, AW first, then both together
    for (int i = 0; i < 3; i++) begin
      aw_lat = lat_aw[i];
      w_lat  = lat_w[i];
      aw_hs = 0;
      w_hs  = 0;
      exp_q.push_back(32'h0);
      send_cmd(2'b00, 12'h010, 32'h0000_00AB, 4'hF, 32'h0, acc);
      get_rsp($sformatf("wr%0d", i), 2'b00, 1'b0, rc);
      check($sformatf("wr%0d_aw_hs", i), 32'(aw_hs), 32'd1);
      check($sformatf("wr%0d_w_hs", i), 32'(w_hs), 32'd1);
      check($sformatf("wr%0d_awaddr", i), 32'(last_awaddr), 32'h010);
      check($sformatf("wr%0d_wdata", i), last_wdata, 32'h0000_00AB);
      check($sformatf("wr%0d_wstrb", i), 32'(last_wstrb), 32'hF);
      if (i == 2) check("wr_latency", 32'(rc - acc), 32'd3);
    end
    aw_lat = 0;
    w_lat  = 0;

    // Read latency with an always-ready slave
    ar_hs = 0;
    rd_q.push_back(32'h4);
    exp_q.push_back(32'h4);
    send_cmd(2'b01, 12'h000, 32'h0, 4'h0, 32'h0, acc);
    get_rsp("rd", 2'b00, 1'b0, rc);
    check("rd_latency", 32'(rc - acc), 32'd3);
    check("rd_busy_c0", 32'(busy_log[acc % 1024]), 32'd0);
    for (int k = 1; k <= 3; k++)
      check($sformatf("rd_busy_c%0d", k), 32'(busy_log[(acc + k) % 1024]), 32'd1);
    check("rd_ar_hs", 32'(ar_hs), 32'd1);
    check("rd_araddr", 32'(last_araddr), 32'h000);

    // Poll matching on the first read
    ar_hs = 0;
    rd_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h0000_0002);
    send_cmd(2'b10, 12'h000, 32'h2, 4'h0, 32'h2, acc);
    get_rsp("poll1", 2'b00, 1'b0, rc);
    check("poll1_latency", 32'(rc - acc), 32'd3);
    check("poll1_ar_hs", 32'(ar_hs), 32'd1);

    // Poll for done: 0x4, 0x4, then 0x6 matches on the last allowed attempt
    ar_hs = 0;
    ar_cyc_q.delete();
    r_cyc_q.delete();
    rd_q.push_back(32'h4);
    rd_q.push_back(32'h4);
    rd_q.push_back(32'h6);
    exp_q.push_back(32'h6);
    send_cmd(2'b10, 12'h000, 32'h2, 4'h0, 32'h2, acc);
    get_rsp("poll_done", 2'b00, 1'b0, rc);
    check("poll_done_ar_hs", 32'(ar_hs), 32'd3);
    if (ar_cyc_q.size() >= 3 && r_cyc_q.size() >= 2) begin
      check("poll_gap1", 32'(ar_cyc_q[1] - r_cyc_q[0]), 32'd5);
      check("poll_gap2", 32'(ar_cyc_q[2] - r_cyc_q[1]), 32'd5);
    end else begin
      check("poll_ar_log", 32'(ar_cyc_q.size()), 32'd3);
    end

    // Poll timeout: slave keeps returning 0
    ar_hs = 0;
    exp_q.push_back(32'h0);
    send_cmd(2'b10, 12'h000, 32'h2, 4'h0, 32'h2, acc);
    get_rsp("poll_to", 2'b00, 1'b1, rc);
    check("poll_to_ar_hs", 32'(ar_hs), 32'd3);

    // SLVERR on the first poll read stops the poll
    ar_hs = 0;
    rresp_cfg = 2'b10;
    rd_q.push_back(32'h4);
    exp_q.push_back(32'h4);
    send_cmd(2'b10, 12'h000, 32'h2, 4'h0, 32'h2, acc);
    get_rsp("poll_err", 2'b10, 1'b0, rc);
    check("poll_err_ar_hs", 32'(ar_hs), 32'd1);
    rresp_cfg = 2'b00;

    // SLVERR on B
    bresp_cfg = 2'b10;
    exp_q.push_back(32'h0);
    send_cmd(2'b00, 12'h020, 32'h1234_5678, 4'h3, 32'h0, acc);
    get_rsp("wr_err", 2'b10, 1'b0, rc);
    check("wr_err_wstrb", 32'(last_wstrb), 32'h3);
    bresp_cfg = 2'b00;

    // Invalid op: straight to response, no bus traffic
    valid_seen = 0;
    exp_q.push_back(32'h0);
    send_cmd(2'b11, 12'h030, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, acc);
    get_rsp("inv", 2'b11, 1'b0, rc);
    check("inv_latency", 32'(rc - acc), 32'd1);
    check("inv_no_valids", 32'(valid_seen), 32'd0);

    // Response backpressure: hold rsp_ready low for 10 cycles
    rd_q.push_back(32'h0000_0055);
    exp_q.push_back(32'h0000_0055);
    rsp_ready = 1'b0;
    send_cmd(2'b01, 12'h004, 32'h0, 4'h0, 32'h0, acc);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    s_rdata = rsp_rdata;
    s_resp  = rsp_resp;
    s_to    = rsp_timeout;
    valid_seen = 0;
    stable = 1;
    hi_cnt = 0;
    repeat (10) begin
      @(negedge ap_clk);
      if (!rsp_valid || rsp_rdata !== s_rdata || rsp_resp !== s_resp || rsp_timeout !== s_to)
        stable = 0;
      if (cmd_ready || m_axi_if.bready || m_axi_if.rready) hi_cnt++;
    end
    check("bp_rsp_stable", 32'(stable), 32'd1);
    check("bp_ready_lines", 32'(hi_cnt), 32'd0);
    check("bp_no_valids", 32'(valid_seen), 32'd0);
    get_rsp("bp", 2'b00, 1'b0, rc);
    check("bp_next_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset while arvalid is held by a slow slave
    ar_lat = 20;
    send_cmd(2'b01, 12'h008, 32'h0, 4'h0, 32'h0, acc);
    n = 0;
    while (!m_axi_if.arvalid && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    check("mid_arvalid", 32'(m_axi_if.arvalid), 32'd1);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_arvalid", 32'(m_axi_if.arvalid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    ap_rst_n = 1'b1;
    ar_lat = 0;
    @(negedge ap_clk);
    check("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rel_busy", 32'(busy), 32'd0);
    hi_cnt = 0;
    repeat (5) begin
      @(negedge ap_clk);
      if (rsp_valid) hi_cnt++;
    end
    check("mid_no_rsp", 32'(hi_cnt), 32'd0);

    // Normal read after the abort
    rd_q.delete();
    rd_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    send_cmd(2'b01, 12'h008, 32'h0, 4'h0, 32'h0, acc);
    get_rsp("rd_after", 2'b00, 1'b0, rc);
    check("rd_after_araddr", 32'(last_araddr), 32'h008);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
